// File: rtl/data_mem_port.sv
// data_mem_port: load/store initiator for a byte-addressed 32-bit memory, with read-modify-write for SB/SH.
// Optional tohost write watch enabled by defining DATA_MEM_PORT_TOHOST_WATCH_EN.
module data_mem_port #(
    parameter logic [31:0] MEM_BASE = 32'h80000000,
    parameter int MEM_SIZE = 16384
`ifdef DATA_MEM_PORT_TOHOST_WATCH_EN
    ,
    parameter logic [31:0] TOHOST_ADDR = 32'h80001000
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic        mem_we,
    output logic [31:0] mem_waddr,
`ifdef DATA_MEM_PORT_TOHOST_WATCH_EN
    output logic        tohost_written,
    output logic [31:0] tohost_value,
`endif
    output logic [31:0] mem_wdata
);
    typedef enum logic [2:0] {IDLE, LOAD, READ, WRITE, RESP} state_t;
    state_t r_state, w_next;
    logic [2:0]  r_funct3;
    logic [15:0] r_wdata;
    logic [31:0] r_mem_addr, r_mem_waddr, r_mem_wdata, r_rdata;
    logic        r_err;
    logic [32:0] w_hi;
    logic        w_bad_code, w_fault;
    logic [31:0] w_load, w_merge;

    assign w_hi = {1'b0, MEM_BASE} + 33'(MEM_SIZE) - 33'd4;
    assign w_bad_code = req_is_store ? (req_funct3 > 3'd2) : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
    assign w_fault = w_bad_code || ({1'b0, req_addr} < {1'b0, MEM_BASE}) || ({1'b0, req_addr} > w_hi);
    // funct3[2] selects zero extension, [1] word, [0] halfword
    assign w_load = r_funct3[1] ? mem_rdata :
                    r_funct3[0] ? {{16{~r_funct3[2] & mem_rdata[15]}}, mem_rdata[15:0]} :
                                  {{24{~r_funct3[2] & mem_rdata[7]}}, mem_rdata[7:0]};
    assign w_merge = r_funct3[0] ? {mem_rdata[31:16], r_wdata} : {mem_rdata[31:8], r_wdata[7:0]};

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_next = w_fault ? RESP : !req_is_store ? LOAD : (req_funct3 == 3'b010) ? WRITE : READ;
            LOAD:    w_next = RESP;
            READ:    w_next = WRITE;
            WRITE:   w_next = RESP;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_funct3    <= '0;
            r_wdata     <= '0;
            r_mem_addr  <= MEM_BASE;
            r_mem_waddr <= MEM_BASE;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (req_valid) begin
                    r_funct3 <= req_funct3;
                    r_wdata  <= req_wdata[15:0];
                    if (w_fault) begin
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                    end else if (req_is_store && req_funct3 == 3'b010) begin
                        r_mem_waddr <= req_addr;
                        r_mem_wdata <= req_wdata;
                    end else begin
                        r_mem_addr <= req_addr;
                    end
                end
                LOAD: begin
                    r_rdata <= w_load;
                    r_err   <= 1'b0;
                end
                READ: begin
                    r_mem_waddr <= r_mem_addr;
                    r_mem_wdata <= w_merge;
                end
                WRITE: begin
                    r_rdata <= '0;
                    r_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign resp_valid = (r_state == RESP);
    assign mem_we     = (r_state == WRITE);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;
    assign mem_addr   = r_mem_addr;
    assign mem_waddr  = r_mem_waddr;
    assign mem_wdata  = r_mem_wdata;

`ifdef DATA_MEM_PORT_TOHOST_WATCH_EN
    logic        r_th_written;
    logic [31:0] r_th_value;
    logic        w_th_hit;

    assign w_th_hit = mem_we && (r_mem_waddr == TOHOST_ADDR);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_th_written <= 1'b0;
            r_th_value   <= '0;
        end else begin
            r_th_written <= w_th_hit;
            if (w_th_hit) r_th_value <= r_mem_wdata;
        end
    end

    assign tohost_written = r_th_written;
    assign tohost_value   = r_th_value;
`endif
endmodule

// File: tb/tb_data_mem_port.sv
// tb_data_mem_port: table-driven check of data_mem_port against a byte-array memory model.
module tb_data_mem_port;
    logic        clk = 1'b0;
    logic        reset, req_valid, req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_err, mem_we;
    logic [31:0] resp_rdata, mem_addr, mem_rdata, mem_waddr, mem_wdata;
`ifdef DATA_MEM_PORT_TOHOST_WATCH_EN
    logic        tohost_written;
    logic [31:0] tohost_value;
    int          n_th = 0;
`endif

    data_mem_port dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_is_store(req_is_store), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_we(mem_we),
        .mem_waddr(mem_waddr),
`ifdef DATA_MEM_PORT_TOHOST_WATCH_EN
        .tohost_written(tohost_written), .tohost_value(tohost_value),
`endif
        .mem_wdata(mem_wdata)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:16383];
    logic [31:0] r_off, w_off;
    int          n_we = 0;
    logic [31:0] we_addr, we_data;
    int          n_cmp = 0, n_bad = 0;

    assign r_off = mem_addr - 32'h80000000;
    assign w_off = mem_waddr - 32'h80000000;
    assign mem_rdata = (r_off <= 32'd16380) ?
        {mem[int'(r_off) + 3], mem[int'(r_off) + 2], mem[int'(r_off) + 1], mem[int'(r_off)]} : 32'h0;

    always @(posedge clk) begin
        if (mem_we) begin
            n_we++;
            we_addr = mem_waddr;
            we_data = mem_wdata;
            if (w_off <= 32'd16380)
                for (int k = 0; k < 4; k++) mem[int'(w_off) + k] <= mem_wdata[8*k +: 8];
        end
`ifdef DATA_MEM_PORT_TOHOST_WATCH_EN
        if (tohost_written) n_th++;
`endif
    end

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a, wd;
        int          lat;
        logic [31:0] rd;
        logic        err;
        int          nwe;
        logic [31:0] wa, wdx;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic st, logic [2:0] f3, logic [31:0] a, wd, int lat,
                                logic [31:0] rd, logic err, int nwe, logic [31:0] wa, wdx);
        vec_t v;
        v.st = st; v.f3 = f3; v.a = a; v.wd = wd; v.lat = lat;
        v.rd = rd; v.err = err; v.nwe = nwe; v.wa = wa; v.wdx = wdx;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic run(input vec_t t, input string nm);
        int lat, we0;
        @(negedge clk);
        chk({nm, ".ready"}, 32'(req_ready), 32'd1);
        req_is_store = t.st; req_funct3 = t.f3; req_addr = t.a; req_wdata = t.wd;
        req_valid = 1'b1;
        we0 = n_we;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 99;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = c;
                break;
            end
        end
        chk({nm, ".lat"}, 32'(lat), 32'(t.lat));
        chk({nm, ".rdata"}, resp_rdata, t.rd);
        chk({nm, ".err"}, 32'(resp_err), 32'(t.err));
        chk({nm, ".nwe"}, 32'(n_we - we0), 32'(t.nwe));
        if (t.nwe != 0) begin
            chk({nm, ".waddr"}, we_addr, t.wa);
            chk({nm, ".wdata"}, we_data, t.wdx);
            chk({nm, ".waddr_hold"}, mem_waddr, t.wa);
        end
        @(negedge clk);
        chk({nm, ".pulse"}, {30'd0, resp_valid, req_ready}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit seen;
        for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
        {mem[16'h13], mem[16'h12], mem[16'h11], mem[16'h10]} = 32'hDEADBEEF;
        {mem[16'h22], mem[16'h21]} = 16'h8001;
        {mem[16'h08], mem[16'h07], mem[16'h06], mem[16'h05]} = 32'h11223344;
        {mem[16'h103], mem[16'h102], mem[16'h101], mem[16'h100]} = 32'h12345678;
        {mem[16'h3FFF], mem[16'h3FFE], mem[16'h3FFD], mem[16'h3FFC]} = 32'h0BADF00D;

        reset = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.ready", 32'(req_ready), 32'd1);
        chk("rst.flags", {29'd0, resp_valid, resp_err, mem_we}, 32'd0);
        chk("rst.rdata", resp_rdata, 32'd0);
        chk("rst.mem_addr", mem_addr, 32'h80000000);
        chk("rst.mem_waddr", mem_waddr, 32'h80000000);
        chk("rst.mem_wdata", mem_wdata, 32'd0);
        reset = 1'b0;

        tv.push_back(mk(0, 3'b010, 32'h80000010, 0,            2, 32'hDEADBEEF, 0, 0, 0, 0));
        tv.push_back(mk(1, 3'b000, 32'h80000013, 32'h00000080, 3, 0, 0, 1, 32'h80000013, 32'h00000080));
        tv.push_back(mk(0, 3'b000, 32'h80000013, 0,            2, 32'hFFFFFF80, 0, 0, 0, 0));
        tv.push_back(mk(0, 3'b100, 32'h80000013, 0,            2, 32'h00000080, 0, 0, 0, 0));
        tv.push_back(mk(0, 3'b001, 32'h80000021, 0,            2, 32'hFFFF8001, 0, 0, 0, 0));
        tv.push_back(mk(0, 3'b101, 32'h80000021, 0,            2, 32'h00008001, 0, 0, 0, 0));
        tv.push_back(mk(1, 3'b000, 32'h80000005, 32'h000000AB, 3, 0, 0, 1, 32'h80000005, 32'h112233AB));
        tv.push_back(mk(0, 3'b010, 32'h80000005, 0,            2, 32'h112233AB, 0, 0, 0, 0));
        tv.push_back(mk(0, 3'b000, 32'h80000008, 0,            2, 32'h00000011, 0, 0, 0, 0));
        tv.push_back(mk(1, 3'b001, 32'h80000100, 32'h0000CAFE, 3, 0, 0, 1, 32'h80000100, 32'h1234CAFE));
        tv.push_back(mk(0, 3'b010, 32'h80000100, 0,            2, 32'h1234CAFE, 0, 0, 0, 0));
        tv.push_back(mk(1, 3'b010, 32'h80000200, 32'h55AA55AA, 2, 0, 0, 1, 32'h80000200, 32'h55AA55AA));
        tv.push_back(mk(0, 3'b010, 32'h80000200, 0,            2, 32'h55AA55AA, 0, 0, 0, 0));
        tv.push_back(mk(1, 3'b001, 32'h80000300, 32'hFFFFBEEF, 3, 0, 0, 1, 32'h80000300, 32'h0000BEEF));
        tv.push_back(mk(0, 3'b010, 32'h80003FFC, 0,            2, 32'h0BADF00D, 0, 0, 0, 0));
        tv.push_back(mk(0, 3'b010, 32'h7FFFFFFC, 0,            1, 0, 1, 0, 0, 0));
        tv.push_back(mk(1, 3'b010, 32'h80003FFD, 32'h12345678, 1, 0, 1, 0, 0, 0));
        tv.push_back(mk(0, 3'b010, 32'hFFFFFFFC, 0,            1, 0, 1, 0, 0, 0));
        tv.push_back(mk(0, 3'b011, 32'h80000010, 0,            1, 0, 1, 0, 0, 0));
        tv.push_back(mk(0, 3'b110, 32'h80000010, 0,            1, 0, 1, 0, 0, 0));
        tv.push_back(mk(1, 3'b100, 32'h80000010, 32'h12345678, 1, 0, 1, 0, 0, 0));
        tv.push_back(mk(1, 3'b010, 32'h80003FFC, 32'hA5A5A5A5, 2, 0, 0, 1, 32'h80003FFC, 32'hA5A5A5A5));

        foreach (tv[i]) run(tv[i], $sformatf("v%0d", i));

        // Reset while an SB is in its write cycle: operation must be dropped silently.
        @(negedge clk);
        req_is_store = 1'b1; req_funct3 = 3'b000; req_addr = 32'h80000040; req_wdata = 32'h77;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rstmid.we_before", 32'(mem_we), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("rstmid.we_after", 32'(mem_we), 32'd0);
        chk("rstmid.resp", 32'(resp_valid), 32'd0);
        chk("rstmid.ready", 32'(req_ready), 32'd1);
        reset = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        chk("rstmid.no_resp", 32'(seen), 32'd0);

`ifdef DATA_MEM_PORT_TOHOST_WATCH_EN
        chk("th.reset", {31'd0, tohost_written} | tohost_value, 32'd0);
        run(mk(1, 3'b010, 32'h80001000, 32'h00000001, 2, 0, 0, 1, 32'h80001000, 32'h00000001), "th");
        chk("th.pulses", 32'(n_th), 32'd1);
        chk("th.value", tohost_value, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/data_mem_port.md
Name: data_mem_port

Overview:
- Core-side initiator for the byte-addressed, 32-bit-wide test memory. It turns RISC-V load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into memory read and write cycles.
- The memory always reads and writes 4 consecutive bytes starting at any byte address. Sub-word stores therefore need read-modify-write, and loads need extraction plus sign/zero extension.
- Sits between the core's execute/MEM stage and the memory, with a valid/ready request and a one-cycle response pulse.

Parameters:
- MEM_BASE, 32'h80000000, first valid byte address.
- MEM_SIZE, 16384, memory size in bytes.
- TOHOST_ADDR, 32'h80001000, tohost word address (optional feature only).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_is_store  input  1  1=store, 0=load.
- req_funct3  input  3  RISC-V funct3 width/sign code.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, low bytes significant.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  32  extended load result; 0 for stores and faults.
- resp_err  output  1  fault flag, valid with resp_valid.
- mem_addr  output  32  memory read address.
- mem_rdata  input  32  combinational read data: bytes mem_addr+3..mem_addr.
- mem_we  output  1  memory write enable (level-sensitive at the memory).
- mem_waddr  output  32  memory write address.
- mem_wdata  output  32  memory write data.

Behaviour:
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_addr=MEM_BASE, mem_waddr=MEM_BASE, mem_wdata=0.
- Reset mid-operation: abandons the operation at the next edge; mem_we deasserts; no response is issued.
- States: IDLE, LOAD, READ, WRITE, RESP.
- req_ready=1 only in IDLE. A request is accepted on req_valid&req_ready, and addr/funct3/wdata/is_store are latched.
- Legal codes:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is a fault.
- Range fault: addr < MEM_BASE or addr > MEM_BASE+MEM_SIZE-4. Compare in 33 bits, with no wrap.
  - Any fault goes IDLE->RESP with resp_err=1 and rdata=0.
  - No memory cycle is issued on a fault: mem_we stays 0.
- Load: IDLE->LOAD->RESP.
  - In LOAD, mem_addr=addr and mem_rdata is captured.
  - Byte = rdata[7:0]; half = rdata[15:0].
  - Sign-extend for LB/LH; zero-extend for LBU/LHU.
  - resp_valid is asserted 2 cycles after acceptance.
- SW: IDLE->WRITE->RESP. mem_we=1 for exactly one cycle in WRITE, with mem_waddr=addr and mem_wdata=wdata.
- SB/SH: IDLE->READ->WRITE->RESP.
  - READ captures the old word at addr.
  - WRITE writes the merged word:
    - SB = {old[31:8], wdata[7:0]}.
    - SH = {old[31:16], wdata[15:0]}.
  - resp_valid is asserted 3 cycles after acceptance.
- mem_waddr/mem_wdata are registered. They are set on entry to WRITE and held stable while mem_we=1, and stay held afterwards.
- mem_addr holds its last value outside LOAD/READ.
- RESP lasts exactly one cycle, then the block returns to IDLE. resp_err/resp_rdata hold until the next RESP.
- No misalignment restriction: any byte address in range is legal.
- Back-to-back requests: the earliest acceptance is the cycle after RESP.

Optional Feature:
- Macro: DATA_MEM_PORT_TOHOST_WATCH_EN.
- With the macro defined:
  - Extra outputs tohost_written (1 bit) and tohost_value (32 bits).
  - When a WRITE cycle has mem_waddr==TOHOST_ADDR, tohost_written pulses for one cycle on the following edge, and tohost_value latches mem_wdata.
  - Both reset to 0.
- Without the macro: these ports do not exist, and there is no added logic.

Test Plan:
- LW at 0x80000010, memory holds 0xDEADBEEF -> resp_valid 2 cycles after acceptance, rdata=0xDEADBEEF, err=0, mem_we never asserted.
- LB/LBU at 0x80000013, byte 0x80 -> LB rdata=0xFFFFFF80, LBU rdata=0x00000080. LH at an odd address 0x80000021, half 0x8001 -> 0xFFFF8001.
- SB 0x000000AB at 0x80000005 over 0x11223344 -> exactly one mem_we cycle writing 0x112233AB at 0x80000005; response 3 cycles after acceptance; a following LW reads 0x112233AB.
- SH 0x0000CAFE at 0x80000100 over 0x12345678 -> writes 0x1234CAFE. SW 0x55AA55AA -> single-cycle write, response 2 cycles after acceptance.
- Faults:
  - LW at 0x7FFFFFFC -> resp_err=1 one cycle after acceptance, rdata=0, no mem_we.
  - SW at MEM_BASE+MEM_SIZE-3 -> err.
  - Load funct3=011 -> err.
  - Store funct3=100 -> err.
- Assert reset during WRITE of an SB -> next cycle IDLE, mem_we=0, no resp_valid. With DATA_MEM_PORT_TOHOST_WATCH_EN defined: SW 0x00000001 to 0x80001000 -> tohost_written pulse, tohost_value=1.
